seq_mul_responder: RTL and testbench
====================================

SEQ_MUL_RESPONDER -- requirements
Module: seq_mul_responder

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; result width is 2*WIDTH.
REQ-002 Clock  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 iStart  input  1  request strobe; operands valid in same cycle.
REQ-005 iA  input  WIDTH  multiplicand.
REQ-006 iB  input  WIDTH  multiplier.
REQ-007 oBusy  output  1  high while an operation is in progress.
REQ-008 oDone  output  1  one-cycle pulse; oResult valid.
REQ-009 oResult  output  2*WIDTH  product, held until the next completion or Reset.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 IDLE or DONE with iStart=1 at an edge: SHALL capture iA/iB, clear the partial product, load bit counter = 0, and go to RUN.
REQ-012 IDLE with iStart=0: SHALL stay in IDLE.
REQ-013 DONE with iStart=0: SHALL go to IDLE.
REQ-014 RUN: SHALL process one multiplier bit per cycle, radix-2 shift-add (add the shifted multiplicand when the current bit is 1).
REQ-015 RUN: SHALL ignore iStart (no capture, no restart, no error).
REQ-016 RUN: after the WIDTH-th iteration edge, SHALL register the final product into oResult and enter DONE.
REQ-017 Latency: start accepted at edge N -> oDone=1 in the cycle following edge N+WIDTH (16 cycles for default WIDTH).
REQ-018 oBusy SHALL equal (state==RUN).
REQ-019 oDone SHALL equal (state==DONE), so it is exactly one cycle wide unless a back-to-back start is accepted.
REQ-020 A back-to-back start accepted in DONE SHALL deassert oDone on the next cycle and assert oBusy.
REQ-021 oResult SHALL change only on entry to DONE and on Reset.
REQ-022 oResult SHALL be the exact 2*WIDTH-bit product with no truncation or overflow; the low half is result bits [WIDTH-1:0] and the high half is bits [2*WIDTH-1:WIDTH].
REQ-023 Operands SHALL be sampled only at acceptance; changes to iA/iB during RUN SHALL NOT affect the result.

Reset
REQ-024 Reset=1 at an edge SHALL force IDLE, oBusy=0, oDone=0, oResult=0, and clear the counter and partial product.
REQ-025 Reset SHALL take priority over iStart in every state.
REQ-026 Reset during RUN SHALL abort the operation with no oDone pulse for that operation.

Configuration
REQ-027 Macro SEQ_MUL_SIGNED_EN defined: iA, iB and oResult SHALL be two's complement.
REQ-028 Signed handling: the magnitudes SHALL be captured at acceptance, multiplied unsigned, and the product negated on entry to DONE when the operand signs differ.
REQ-029 Macro SEQ_MUL_SIGNED_EN defined: latency SHALL be unchanged from REQ-017.
REQ-030 Macro SEQ_MUL_SIGNED_EN undefined: all operands and the result SHALL be unsigned, and no sign logic SHALL be synthesized.
REQ-031 A most-negative operand (0x8000 for WIDTH=16) SHALL be handled correctly in signed mode.

Verification
REQ-032 Unsigned: iA=3, iB=5, start at edge 0 -> oBusy=1 for edges 1..16; oDone=1 only after edge 16; oResult=0x0000000F.
REQ-033 Unsigned: iA=0xFFFF, iB=0xFFFF -> oResult=0xFFFE0001; iA=0, iB=0x1234 -> oResult=0.
REQ-034 Signed build: iA=0xFFFE (-2), iB=3 -> oResult=0xFFFFFFFA.
REQ-035 Signed build: iA=iB=0x8000 -> oResult=0x40000000.
REQ-036 Busy/back-to-back: iStart pulsed with iA=7, iB=7 at edge 5 of an ongoing 2*3 operation -> result 6 delivered and 7*7 ignored; a start held in the DONE cycle -> second result on schedule with no IDLE gap.
REQ-037 Reset mid-op: Reset asserted at iteration 8 -> next cycle IDLE, oResult=0, no oDone; a subsequent start completes normally.

Source files
------------

// File: rtl/seq_mul_responder.sv
// Sequential radix-2 shift-add multiplier with a start/busy/done handshake.
// Optional SEQ_MUL_SIGNED_EN: two's complement operands and result (sign-magnitude internally).
module seq_mul_responder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e stateQ, stateD;

  logic [2*WIDTH-1:0] mcandQ, mcandD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [2*WIDTH-1:0] resultQ, resultD;
  logic [WIDTH-1:0]   mplierQ, mplierD;
  logic [CntW-1:0]    cntQ, cntD;

  logic               lastIter;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   magA, magB;

  assign lastIter = (cntQ == LastCnt);
  assign accNext  = mplierQ[0] ? (accQ + mcandQ) : accQ;

`ifdef SEQ_MUL_SIGNED_EN
  localparam logic [WIDTH-1:0]   OpOne   = 1;
  localparam logic [2*WIDTH-1:0] ProdOne = 1;

  logic negQ, negD;

  // The most-negative value maps to magnitude 2^(WIDTH-1), which still fits unsigned.
  assign magA    = iA[WIDTH-1] ? (~iA + OpOne) : iA;
  assign magB    = iB[WIDTH-1] ? (~iB + OpOne) : iB;
  assign product = negQ ? (~accNext + ProdOne) : accNext;
`else
  assign magA    = iA;
  assign magB    = iB;
  assign product = accNext;
`endif

  always_comb begin
    stateD  = stateQ;
    mcandD  = mcandQ;
    accD    = accQ;
    resultD = resultQ;
    mplierD = mplierQ;
    cntD    = cntQ;
`ifdef SEQ_MUL_SIGNED_EN
    negD    = negQ;
`endif

    unique case (stateQ)
      StIdle, StDone: begin
        if (iStart) begin
          mcandD  = {{WIDTH{1'b0}}, magA};
          mplierD = magB;
          accD    = '0;
          cntD    = '0;
`ifdef SEQ_MUL_SIGNED_EN
          negD    = iA[WIDTH-1] ^ iB[WIDTH-1];
`endif
          stateD  = StRun;
        end else begin
          stateD  = StIdle;
        end
      end

      // iStart is deliberately not looked at here.
      StRun: begin
        accD    = accNext;
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        cntD    = cntQ + CntOne;
        if (lastIter) begin
          resultD = product;
          cntD    = '0;
          stateD  = StDone;
        end
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ  <= StIdle;
      mcandQ  <= '0;
      accQ    <= '0;
      resultQ <= '0;
      mplierQ <= '0;
      cntQ    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      negQ    <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      mcandQ  <= mcandD;
      accQ    <= accD;
      resultQ <= resultD;
      mplierQ <= mplierD;
      cntQ    <= cntD;
`ifdef SEQ_MUL_SIGNED_EN
      negQ    <= negD;
`endif
    end
  end

  assign oBusy   = (stateQ == StRun);
  assign oDone   = (stateQ == StDone);
  assign oResult = resultQ;

endmodule

// File: tb/tb_seq_mul_responder.sv
// Directed, table-driven bench for seq_mul_responder (WIDTH=16), plus hand-written
// sequences for busy-ignore, back-to-back start and mid-operation reset.
module tb_seq_mul_responder;

  localparam int unsigned W = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iStart;
  logic [W-1:0]  iA, iB;
  logic          oBusy, oDone;
  logic [2*W-1:0] oResult;

  int total = 0;
  int bad   = 0;

  seq_mul_responder #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present operands with iStart over one rising edge, then scramble them; returns at the
  // falling edge right after the accepting edge.
  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
    iA = a;
    iB = b;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    iA = ~a;
    iB = b ^ 16'h5A5A;
  endtask

  // Counts edges until oDone is seen (bounded); flags any cycle before that without oBusy.
  task automatic waitDone(output int edges, output logic busyOk);
    edges  = 0;
    busyOk = 1'b1;
    while (!oDone && edges < 40) begin
      if (!oBusy) busyOk = 1'b0;
      @(negedge Clock);
      edges++;
    end
  endtask

  initial begin
    int edges;
    logic busyOk;
    logic sawDone;

`ifdef SEQ_MUL_SIGNED_EN
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[3] = '{16'hFFFE, 16'h0003, 32'hFFFFFFFA};
    vecs[4] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[5] = '{16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[6] = '{16'h7FFF, 16'h8000, 32'hC0008000};
`else
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[3] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
    vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[6] = '{16'h0001, 16'h8001, 32'h00008001};
`endif

    Reset = 1'b1;
    iStart = 1'b0;
    iA = '0;
    iB = '0;
    repeat (3) @(negedge Clock);
    check("reset busy", 64'(oBusy), 64'd0);
    check("reset done", 64'(oDone), 64'd0);
    check("reset result", 64'(oResult), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 7; i++) begin
      startOp(vecs[i].a, vecs[i].b);
      waitDone(edges, busyOk);
      check($sformatf("vec%0d latency", i), 64'(edges), 64'(W));
      check($sformatf("vec%0d busy", i), 64'(busyOk), 64'd1);
      check($sformatf("vec%0d result", i), 64'(oResult), 64'(vecs[i].p));
      @(negedge Clock);
      check($sformatf("vec%0d done width", i), 64'(oDone), 64'd0);
      check($sformatf("vec%0d held", i), 64'(oResult), 64'(vecs[i].p));
    end

    // Start pulsed while busy must be ignored.
    startOp(16'd2, 16'd3);
    repeat (4) @(negedge Clock);
    iA = 16'd7;
    iB = 16'd7;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    waitDone(edges, busyOk);
    check("ignore latency", 64'(edges + 5), 64'(W));
    check("ignore result", 64'(oResult), 64'd6);

    // Start held during the DONE cycle: straight back into RUN.
    iA = 16'd9;
    iB = 16'd9;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    check("b2b done low", 64'(oDone), 64'd0);
    check("b2b busy", 64'(oBusy), 64'd1);
    check("b2b result held", 64'(oResult), 64'd6);
    waitDone(edges, busyOk);
    check("b2b latency", 64'(edges), 64'(W));
    check("b2b result", 64'(oResult), 64'd81);
    @(negedge Clock);

    // Reset at iteration 8 aborts with no done pulse.
    startOp(16'h1234, 16'h5678);
    repeat (7) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort busy", 64'(oBusy), 64'd0);
    check("abort done", 64'(oDone), 64'd0);
    check("abort result", 64'(oResult), 64'd0);
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      if (oDone || oBusy) sawDone = 1'b1;
    end
    check("abort quiet", 64'(sawDone), 64'd0);

    // Reset wins over a simultaneous start.
    iA = 16'd3;
    iB = 16'd3;
    iStart = 1'b1;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    iStart = 1'b0;
    check("reset prio busy", 64'(oBusy), 64'd0);
    @(negedge Clock);
    check("reset prio idle", 64'(oBusy), 64'd0);

    startOp(16'd3, 16'd5);
    waitDone(edges, busyOk);
    check("post-reset latency", 64'(edges), 64'(W));
    check("post-reset result", 64'(oResult), 64'h0F);
    @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
